key_press_classifier: RTL and testbench



---
 rtl/key_press_classifier.sv | 140 ++++++++++++++
 tb/tb_key_press_classifier.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_press_classifier.sv
// Push-button front end: synchronises and debounces an active-low key and
// classifies each press into short, long and auto-repeat single-cycle events.
module key_press_classifier #(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int LONG_TICKS     = 100,
  parameter int REPEAT_TICKS   = 20,
  parameter int CNT_W          = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic key_in,
  output logic key_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  localparam logic [3:0]       DB_LAST   = 4'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [3:0]       r_db_cnt;
  logic             r_level;
  state_t           r_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;

  logic w_sample_pressed;
  logic w_differs;
  logic w_db_done;
  logic w_press;
  logic w_release;

  // NOTE: the synchroniser resets to 1 so a key held through reset is seen as
  // a fresh press that must debounce, rather than being accepted instantly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample_pressed = ~r_sync2;
  assign w_differs        = w_sample_pressed != r_level;
  assign w_db_done        = tick && w_differs && (r_db_cnt == DB_LAST);
  assign w_press          = w_db_done && !r_level;
  assign w_release        = w_db_done && r_level;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (tick) begin
      if (!w_differs) begin
        r_db_cnt <= '0;
      end else if (w_db_done) begin
        r_db_cnt <= '0;
        r_level  <= ~r_level;
      end else begin
        r_db_cnt <= r_db_cnt + 4'd1;
      end
    end
  end

  // The FSM reacts to the debounce decision in the same tick cycle, so a
  // release landing on a threshold tick can pre-empt the threshold event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle, which keeps them one clock wide.
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_press) begin
            r_state    <= PRESSED;
            r_hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (w_release) begin
            r_short <= 1'b1;
            r_state <= IDLE;
          end else if (tick) begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_long    <= 1'b1;
              r_state   <= LONG_HELD;
              r_rep_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end
        LONG_HELD: begin
          if (w_release) begin
            r_state <= IDLE;
          end else if (tick) begin
            if (r_rep_cnt == REP_LAST) begin
              r_repeat  <= 1'b1;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign key_level    = r_level;
  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign repeat_pulse = r_repeat;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_key_press_classifier.sv
// Self-checking bench for key_press_classifier: table-driven press scenarios
// with a scoreboard of expected events keyed by the deciding tick number.
module tb_key_press_classifier;

  localparam int EV_NONE  = 0;
  localparam int EV_SHORT = 1;
  localparam int EV_LONG  = 2;
  localparam int EV_REP   = 3;

  typedef struct {
    int kind;
    int tick;
  } exp_t;

  typedef struct {
    string name;
    int    low;
    int    n_ev;
    int    kind [3];
    int    off  [3];
  } vec_t;

  logic clock;
  logic reset;
  logic tick;
  logic key_in;
  logic key_level;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic busy;

  int   n_tests;
  int   n_fail;
  int   tick_no;
  exp_t exp_q [$];

  key_press_classifier dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .key_in       (key_in),
    .key_level    (key_level),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One tick period: key driven in the first cycle, tick in the fourth, so
  // the synchroniser has settled before the sample is taken.
  task automatic tick_period(input logic k);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (c == 0) key_in = k;
      tick = (c == 3);
      if (c == 3) tick_no++;
    end
  endtask

  task automatic peek();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int kind, input int t);
    exp_t e;
    e.kind = kind;
    e.tick = t;
    exp_q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    base = tick_no + 1;
    for (int j = 0; j < v.n_ev; j++) push_exp(v.kind[j], base + v.off[j]);
    for (int i = 0; i < v.low + 25; i++) begin
      tick_period(i < v.low ? 1'b0 : 1'b1);
      if (i == 1) begin
        peek();
        check({v.name, "_level_after_2"}, key_level, (v.low >= 2) ? 1 : 0);
        check({v.name, "_busy_after_2"}, busy, (v.low >= 2) ? 1 : 0);
      end
    end
    check({v.name, "_all_events_seen"}, exp_q.size(), 0);
    check({v.name, "_level_end"}, key_level, 0);
    check({v.name, "_busy_end"}, busy, 0);
    exp_q.delete();
  endtask

  // Scoreboard consumer: every pulse seen is matched against the queue.
  initial begin
    bit   prev_any;
    int   n;
    int   kind;
    exp_t e;
    prev_any = 1'b0;
    forever begin
      @(negedge clock);
      n = int'(short_pulse) + int'(long_pulse) + int'(repeat_pulse);
      if (n != 0) begin
        check("pulse_exclusive", n, 1);
        check("pulse_one_wide", prev_any, 0);
        kind = short_pulse ? EV_SHORT : (long_pulse ? EV_LONG : EV_REP);
        if (exp_q.size() == 0) begin
          check("unexpected_event", kind, EV_NONE);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", kind, e.kind);
          check("event_tick", tick_no, e.tick);
        end
      end
      prev_any = (n != 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    vec_t v;
    int   base;

    vecs[0] = '{"glitch",        1,   0, '{EV_NONE,  EV_NONE, EV_NONE}, '{0,   0,   0}};
    vecs[1] = '{"short50",       50,  1, '{EV_SHORT, EV_NONE, EV_NONE}, '{51,  0,   0}};
    vecs[2] = '{"long_repeat",   152, 3, '{EV_LONG,  EV_REP,  EV_REP},  '{101, 121, 141}};
    vecs[3] = '{"rel_at_hold100",100, 1, '{EV_SHORT, EV_NONE, EV_NONE}, '{101, 0,   0}};
    vecs[4] = '{"rel_at_rep20",  120, 1, '{EV_LONG,  EV_NONE, EV_NONE}, '{101, 0,   0}};
    vecs[5] = '{"min_press",     2,   1, '{EV_SHORT, EV_NONE, EV_NONE}, '{3,   0,   0}};
    vecs[6] = '{"hold99",        99,  1, '{EV_SHORT, EV_NONE, EV_NONE}, '{100, 0,   0}};
    vecs[7] = '{"hold101",       101, 1, '{EV_LONG,  EV_NONE, EV_NONE}, '{101, 0,   0}};

    n_tests = 0;
    n_fail  = 0;
    tick_no = 0;
    reset   = 1'b0;
    key_in  = 1'b0;
    tick    = 1'b0;

    // Reset held with the key pressed: nothing may be accepted.
    for (int i = 0; i < 3; i++) tick_period(1'b0);
    peek();
    check("reset_key_level", key_level, 0);
    check("reset_short", short_pulse, 0);
    check("reset_long", long_pulse, 0);
    check("reset_repeat", repeat_pulse, 0);
    check("reset_busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;

    v = '{"after_reset", 10, 1, '{EV_SHORT, EV_NONE, EV_NONE}, '{11, 0, 0}};
    run_vec(v);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset at hold tick 60 with the key still held.
    base = tick_no + 1;
    for (int i = 0; i < 62; i++) tick_period(1'b0);
    peek();
    check("midhold_busy_before", busy, 1);
    check("midhold_hold_tick", tick_no, base + 61);
    tick  = 1'b0;
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("midhold_reset_level", key_level, 0);
    check("midhold_reset_busy", busy, 0);
    check("midhold_reset_pulses", {short_pulse, long_pulse, repeat_pulse}, 0);
    reset = 1'b1;
    base = tick_no + 1;
    push_exp(EV_LONG, base + 101);
    for (int i = 0; i < 130; i++) begin
      tick_period(i < 105 ? 1'b0 : 1'b1);
      if (i == 1) begin
        peek();
        check("midhold_repress_level", key_level, 1);
      end
    end
    check("midhold_all_events_seen", exp_q.size(), 0);
    check("midhold_busy_end", busy, 0);

    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
